// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: execute redirect, instruction-memory read port and decode handshake.
// The master modport is the fetch unit's view; the slave modport is the surrounding pipeline's view.
interface fetch_unit_if;
  logic        e_pcsrc;
  logic [31:0] e_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pcplus4;

  modport master (
    input  e_pcsrc, e_target, imem_rdata, d_ready,
    output imem_req, imem_addr, d_valid, d_instr, d_pc, d_pcplus4
  );

  modport slave (
    output e_pcsrc, e_target, imem_rdata, d_ready,
    input  imem_req, imem_addr, d_valid, d_instr, d_pc, d_pcplus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, sequential requests to a 1-cycle synchronous imem, 2-entry queue to decode.
// Execute-stage redirects reload the PC and flush the queue and any in-flight response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic [XLEN-1:0]   issue_pc;
  logic [1:0]        count, count_nxt;
  logic              inflight, inflight_nxt;
  logic              kill, kill_nxt;
  logic              head, head_nxt;
  logic              tail, tail_nxt;
  logic [XLEN-1:0]   q_instr [2];
  logic [XLEN-1:0]   q_pc    [2];

  logic              redirect;
  logic              pop;
  logic              issue;
  logic              wr;
  logic [2:0]        occ;

  assign redirect = (state == RUN) & bus.e_pcsrc;
  assign pop      = (count != 2'd0) & bus.d_ready & ~bus.e_pcsrc;
  // Occupancy after this cycle's pop, counting the response still on its way.
  assign occ      = 3'(count) + 3'(inflight) - 3'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      count    <= 2'd0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      count    <= count_nxt;
      inflight <= inflight_nxt;
      kill     <= kill_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    count_nxt    = count;
    inflight_nxt = 1'b0;
    kill_nxt     = 1'b0;
    head_nxt     = head;
    tail_nxt     = tail;
    issue        = 1'b0;
    wr           = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redirect) begin
          // Redirect wins over pop, response write and issue.
          pc_nxt    = bus.e_target & 32'hFFFF_FFFC;
          count_nxt = 2'd0;
          head_nxt  = 1'b0;
          tail_nxt  = 1'b0;
          kill_nxt  = inflight;
        end else begin
          wr    = inflight & ~kill;
          issue = (occ < 3'd2);
          if (issue) pc_nxt = pc + 32'd4;
          if (pop)   head_nxt = ~head;
          if (wr)    tail_nxt = ~tail;
          count_nxt    = 2'(3'(count) + 3'(wr) - 3'(pop));
          inflight_nxt = issue;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Tag each request with its address so the response can be paired with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pc <= 32'd0;
    end else if (issue) begin
      issue_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= 32'd0;
        q_pc[i]    <= 32'd0;
      end
    end else if (wr) begin
      q_instr[tail] <= bus.imem_rdata;
      q_pc[tail]    <= issue_pc;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.d_valid   = (count != 2'd0);
  assign bus.d_instr   = q_instr[head];
  assign bus.d_pc      = q_pc[head];
  assign bus.d_pcplus4 = q_pc[head] + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, random traffic against a queue-based model,
// async reset mid-stream and PC wrap on a second instance.
module tb_fetch_unit;
  localparam logic [31:0] RPC0 = 32'h0000_0100;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;
  int   total = 0;
  int   bad   = 0;

  fetch_unit_if if0 ();
  fetch_unit_if if1 ();

  fetch_unit #(.RESET_PC(RPC0)) dut0 (.clk(clk), .rst_n(rst_n),  .bus(if0));
  fetch_unit #(.RESET_PC(RPC1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // Synchronous instruction memories; garbage when not requested.
  always @(posedge clk) begin
    if0.imem_rdata <= if0.imem_req ? memf(if0.imem_addr) : $urandom;
    if1.imem_rdata <= if1.imem_req ? memf(if1.imem_addr) : $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the decode queue and the outstanding request as plain queues of PCs.
  logic        m_run = 1'b0;
  logic [31:0] m_pc  = RPC0;
  logic [31:0] m_fifo[$];
  logic [31:0] m_pend[$];
  logic        m_v, m_pop, m_req;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0;
      m_pc  = RPC0;
      m_fifo.delete();
      m_pend.delete();
    end else begin
      m_v   = (m_fifo.size() != 0);
      m_pop = m_v && if0.d_ready && !if0.e_pcsrc;
      m_req = m_run && !if0.e_pcsrc &&
              ((m_fifo.size() + m_pend.size() - (m_pop ? 1 : 0)) < 2);
      chk("mdl.req",   32'(if0.imem_req), 32'(m_req));
      chk("mdl.addr",  if0.imem_addr, m_pc);
      chk("mdl.valid", 32'(if0.d_valid), 32'(m_v));
      if (m_v) begin
        chk("mdl.pc",     if0.d_pc, m_fifo[0]);
        chk("mdl.pcp4",   if0.d_pcplus4, m_fifo[0] + 32'd4);
        chk("mdl.instr",  if0.d_instr, memf(m_fifo[0]));
      end
      if (!m_run) begin
        m_run = 1'b1;
      end else if (if0.e_pcsrc) begin
        m_fifo.delete();
        m_pend.delete();
        m_pc = {if0.e_target[31:2], 2'b00};
      end else begin
        if (m_pop) void'(m_fifo.pop_front());
        if (m_pend.size() != 0) m_fifo.push_back(m_pend.pop_front());
        if (m_req) begin
          m_pend.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        src;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[29];

  task automatic setv(input int i, input logic rdy, input logic src, input logic [31:0] tgt,
                      input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
    tbl[i] = '{rdy, src, tgt, req, addr, vld, pc};
  endtask

  initial begin
    rst_n = 1'b0;
    rst1_n = 1'b0;
    if0.d_ready = 1'b1; if0.e_pcsrc = 1'b0; if0.e_target = 32'd0;
    if1.d_ready = 1'b1; if1.e_pcsrc = 1'b0; if1.e_target = 32'd0;

    // Release, stall, redirect with response in flight, redirect on full queue, back-to-back redirects.
    setv( 0, 1, 0, 0, 0, 32'h100, 0, 0);
    setv( 1, 1, 0, 0, 1, 32'h100, 0, 0);
    setv( 2, 1, 0, 0, 1, 32'h104, 0, 0);
    setv( 3, 1, 0, 0, 1, 32'h108, 1, 32'h100);
    setv( 4, 0, 0, 0, 0, 32'h10C, 1, 32'h104);
    setv( 5, 0, 0, 0, 0, 32'h10C, 1, 32'h104);
    setv( 6, 0, 0, 0, 0, 32'h10C, 1, 32'h104);
    setv( 7, 0, 0, 0, 0, 32'h10C, 1, 32'h104);
    setv( 8, 0, 0, 0, 0, 32'h10C, 1, 32'h104);
    setv( 9, 1, 0, 0, 1, 32'h10C, 1, 32'h104);
    setv(10, 1, 0, 0, 1, 32'h110, 1, 32'h108);
    setv(11, 1, 0, 0, 1, 32'h114, 1, 32'h10C);
    setv(12, 1, 1, 32'h2003, 0, 32'h118, 1, 32'h110);
    setv(13, 1, 0, 0, 1, 32'h2000, 0, 0);
    setv(14, 1, 0, 0, 1, 32'h2004, 0, 0);
    setv(15, 1, 0, 0, 1, 32'h2008, 1, 32'h2000);
    setv(16, 0, 0, 0, 0, 32'h200C, 1, 32'h2004);
    setv(17, 0, 0, 0, 0, 32'h200C, 1, 32'h2004);
    setv(18, 0, 1, 32'h3000, 0, 32'h200C, 1, 32'h2004);
    setv(19, 0, 0, 0, 1, 32'h3000, 0, 0);
    setv(20, 0, 0, 0, 1, 32'h3004, 0, 0);
    setv(21, 0, 0, 0, 0, 32'h3008, 1, 32'h3000);
    setv(22, 1, 0, 0, 1, 32'h3008, 1, 32'h3000);
    setv(23, 1, 0, 0, 1, 32'h300C, 1, 32'h3004);
    setv(24, 1, 1, 32'h4000, 0, 32'h3010, 1, 32'h3008);
    setv(25, 1, 1, 32'h5004, 0, 32'h4000, 0, 0);
    setv(26, 1, 0, 0, 1, 32'h5004, 0, 0);
    setv(27, 1, 0, 0, 1, 32'h5008, 0, 0);
    setv(28, 1, 0, 0, 1, 32'h500C, 1, 32'h5004);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",   32'(if0.imem_req), 32'd0);
    chk("rst.valid", 32'(if0.d_valid), 32'd0);
    chk("rst.addr",  if0.imem_addr, RPC0);
    chk("rst.instr", if0.d_instr, 32'd0);
    chk("rst.pc",    if0.d_pc, 32'd0);
    chk("rst.pcp4",  if0.d_pcplus4, 32'd4);

    rst_n = 1'b1;
    for (int k = 0; k < 29; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if0.d_ready  = tbl[k].rdy;
      if0.e_pcsrc  = tbl[k].src;
      if0.e_target = tbl[k].tgt;
      @(negedge clk);
      chk($sformatf("vec%0d.req", k),   32'(if0.imem_req), 32'(tbl[k].req));
      chk($sformatf("vec%0d.addr", k),  if0.imem_addr, tbl[k].addr);
      chk($sformatf("vec%0d.valid", k), 32'(if0.d_valid), 32'(tbl[k].vld));
      if (tbl[k].vld) begin
        chk($sformatf("vec%0d.pc", k),    if0.d_pc, tbl[k].pc);
        chk($sformatf("vec%0d.pcp4", k),  if0.d_pcplus4, tbl[k].pc + 32'd4);
        chk($sformatf("vec%0d.instr", k), if0.d_instr, memf(tbl[k].pc));
      end
    end

    // Random traffic, checked cycle by cycle by the model.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if0.d_ready  = (($urandom % 4) != 0);
      if0.e_pcsrc  = (($urandom % 10) == 0);
      if0.e_target = $urandom;
    end

    // Fill the queue, then drop reset between edges.
    @(posedge clk);
    #1;
    if0.d_ready = 1'b0;
    if0.e_pcsrc = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("full.valid", 32'(if0.d_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(if0.d_valid), 32'd0);
    chk("arst.req",   32'(if0.imem_req), 32'd0);
    chk("arst.addr",  if0.imem_addr, RPC0);
    chk("arst.pc",    if0.d_pc, 32'd0);
    chk("arst.pcp4",  if0.d_pcplus4, 32'd4);
    if0.d_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (k == 1) begin
        chk("restart.req",  32'(if0.imem_req), 32'd1);
        chk("restart.addr", if0.imem_addr, RPC0);
      end
      if (k == 3) begin
        chk("restart.valid", 32'(if0.d_valid), 32'd1);
        chk("restart.pc",    if0.d_pc, RPC0);
      end
    end

    // PC wrap on the second instance.
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      if (k == 1) chk("wrap.addr1", if1.imem_addr, 32'hFFFF_FFF8);
      if (k >= 3) begin
        chk($sformatf("wrap%0d.valid", k), 32'(if1.d_valid), 32'd1);
        chk($sformatf("wrap%0d.pc", k),    if1.d_pc, RPC1 + 32'(4 * (k - 3)));
        chk($sformatf("wrap%0d.instr", k), if1.d_instr, memf(RPC1 + 32'(4 * (k - 3))));
      end
      if (k == 4) chk("wrap.pcp4", if1.d_pcplus4, 32'h0000_0000);
      if (k == 5) chk("wrap.pc0",  if1.d_pc, 32'h0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core. Holds the program counter, issues sequential read requests to a synchronous instruction memory, and buffers returned instructions in a 2-entry queue feeding decode over a valid/ready handshake. It consumes the execute stage's branch decision (`e_pcsrc`) and target, then redirects fetch and flushes all younger instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, address fetched first after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `e_pcsrc`  in  1  execute-stage redirect: taken branch or jump.
- `e_target`  in  32  redirect target address; bits [1:0] are ignored and treated as 0.
- `imem_req`  out  1  read request to instruction memory this cycle.
- `imem_addr`  out  32  word-aligned read address; equals current PC.
- `imem_rdata`  in  32  read data, valid exactly one cycle after the cycle `imem_req`=1.
- `d_valid`  out  1  queue head holds a valid instruction.
- `d_ready`  in  1  decode accepts the head this cycle.
- `d_instr`  out  32  head instruction.
- `d_pc`  out  32  head instruction address.
- `d_pcplus4`  out  32  `d_pc` + 4, modulo 2^32.

## Operation
- States: BOOT and RUN. Reset enters BOOT. BOOT goes to RUN unconditionally after one cycle. `imem_req`=0 in BOOT. RUN is never left except by reset.
- Counters:
  - `count` (0..2) is the number of queue entries.
  - `inflight` (0/1) is a request issued last cycle whose data arrives this cycle.
  - `kill` (0/1) marks the in-flight response as stale.
- `pop` = `d_valid` & `d_ready` & ~`e_pcsrc`.
- Issue rule in RUN: `imem_req` = ~`e_pcsrc` & (`count` + `inflight` − `pop` < 2). On issue, PC ← PC + 4, with wrap 32'hFFFF_FFFC → 0. The issued PC is stored alongside the request for tagging.
- Response: if `inflight`=1 and `kill`=0, write {`imem_rdata`, tagged PC} to the queue tail. If `kill`=1, discard the response.
- Redirect (`e_pcsrc`=1 in RUN), at the clock edge:
  - PC ← {`e_target`[31:2], 2'b00}
  - `count` ← 0, so the queue is flushed.
  - If a request is in flight, `kill` ← 1 for its response.
  - No request is issued in the redirect cycle.
- Redirect takes priority over pop, over response write and over issue in the same cycle.
- A redirect while `d_ready`=0 still flushes.
- Queue: 2-entry circular buffer, head/tail pointers 1 bit each. Overflow is impossible by the issue rule. Write and pop in the same cycle when `count`=2 are legal and keep `count`=2.
- `d_instr`, `d_pc` and `d_pcplus4` come from head-entry registers. They are don't-care when `d_valid`=0 but must not be X after reset.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = BOOT.
  - `count`, `inflight` and `kill` = 0.
  - `imem_req` = 0; `d_valid` = 0.
  - `d_instr` = 0, `d_pc` = 0, `d_pcplus4` = 4; queue storage = 0.
- After `rst_n` rises:
  - Edge 1 moves to RUN.
  - Cycle 1 issues `RESET_PC`.
  - Cycle 2 receives the data.
  - Cycle 3 has `d_valid`=1.
- Fetch latency is 2 cycles from issue to `d_valid`. There is no bypass around the queue.
- Throughput is 1 instruction/cycle with `d_ready` held high: steady state `count`=1, `inflight`=1.
- Decode stall: at most 2 entries are held. Issue resumes in the cycle that `pop`=1.
- Redirect sampled at edge R:
  - Cycle R+1 has `imem_addr` = target, `imem_req`=1, `d_valid`=0.
  - The target instruction appears on `d_valid` in cycle R+3.
  - Back-to-back redirects are legal; the last one wins.
- Asserting `rst_n`=0 mid-operation immediately returns all state to reset values, asynchronously, and abandons any in-flight request.

## Test plan
- Reset release with `RESET_PC`=0x100 and `d_ready`=1:
  - Cycle 1 has `imem_addr`=0x100.
  - `d_valid` rises in cycle 3 with `d_pc`=0x100 and `d_pcplus4`=0x104.
  - `d_pc` then increments by 4 every cycle with no bubbles.
- Decode stall: `d_ready`=0 for 5 cycles after the first instruction.
  - The queue fills to 2 and `imem_req` stays 0.
  - On release, `d_pc` sequence 0x100, 0x104, 0x108… continues with no gap or duplicate.
- Redirect: pulse `e_pcsrc` with `e_target`=0x2003 while `inflight`=1.
  - The next `imem_addr` is 0x2000.
  - The in-flight data is never presented.
  - The first `d_pc` after the redirect is 0x2000, in cycle R+3.
- Redirect during a full-queue stall (`d_ready`=0, `count`=2): both entries are dropped and the next valid `d_pc` equals the target.
- PC wrap: `RESET_PC`=0xFFFF_FFF8 gives a `d_pc` sequence of 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. `d_pcplus4` for 0xFFFF_FFFC is 0.
- Async reset mid-stream: drop `rst_n` between edges while `count`=2. `d_valid` and `imem_req` go 0 immediately, and the restart fetches `RESET_PC` again.
